// File: rtl/taylor_pkg.sv
// Shared types, mode encodings and the elaboration-time coefficient
// function for the Taylor coefficient sequencer.
package taylor_pkg;

  localparam logic MODE_SIN  = 1'b0;
  localparam logic MODE_COS  = 1'b1;
  localparam int   TERMS_MAX = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Floored 2^frac_w / ((2k+2)(2k+3)) for sine, 2^frac_w / ((2k+1)(2k+2)) for cosine.
  function automatic int unsigned coef_calc(input logic mode, input int unsigned k,
                                            input int unsigned frac_w);
    int unsigned den;
    if (mode == MODE_COS) den = (2 * k + 1) * (2 * k + 2);
    else                  den = (2 * k + 2) * (2 * k + 3);
    return (32'd1 << frac_w) / den;
  endfunction

endpackage

// File: rtl/taylor_coef_rom.sv
// Constant sine/cosine coefficient table indexed by (mode, k); every entry
// is folded to a constant at elaboration.
module taylor_coef_rom
  import taylor_pkg::*;
#(
  parameter int FRAC_W  = 8,
  parameter int OUT_W   = 16,
  parameter int N_TERMS = 5,
  parameter int IDX_W   = 3
) (
  input  logic             mode,
  input  logic [IDX_W-1:0] k,
  output logic [OUT_W-1:0] coef
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [OUT_W-1:0] w_sin [DEPTH];
  logic [OUT_W-1:0] w_cos [DEPTH];

  // Unused index slots read as zero so any k value is well defined.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tab
    if (gi < N_TERMS && gi < TERMS_MAX) begin : g_used
      assign w_sin[gi] = OUT_W'(coef_calc(MODE_SIN, gi, FRAC_W));
      assign w_cos[gi] = OUT_W'(coef_calc(MODE_COS, gi, FRAC_W));
    end else begin : g_pad
      assign w_sin[gi] = '0;
      assign w_cos[gi] = '0;
    end
  end

  assign coef = (mode == MODE_COS) ? w_cos[k] : w_sin[k];

endmodule

// File: rtl/taylor_coef_seq.sv
// Streams sine/cosine Taylor coefficients over valid/ready, forward or
// reverse order, with all outputs registered.
module taylor_coef_seq
  import taylor_pkg::*;
#(
  parameter  int FRAC_W  = 8,
  parameter  int OUT_W   = 16,
  parameter  int N_TERMS = 5,
  localparam int IDX_W   = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             rev,
  output logic             busy,
  output logic             coef_valid,
  input  logic             coef_ready,
  output logic [OUT_W-1:0] coef,
  output logic [IDX_W-1:0] term_idx,
  output logic             last,
  output logic             done
);

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N_TERMS - 1);

  state_t           r_state, w_state_next;
  logic             r_mode, w_mode_next;
  logic             r_rev, w_rev_next;
  logic [IDX_W-1:0] r_k, w_k_next;
  logic             r_last, w_last_next;
  logic             r_done, w_done_next;
  logic [OUT_W-1:0] r_coef, w_rom_coef;

  taylor_coef_rom #(
    .FRAC_W (FRAC_W),
    .OUT_W  (OUT_W),
    .N_TERMS(N_TERMS),
    .IDX_W  (IDX_W)
  ) u_rom (
    .mode(w_mode_next),
    .k   (w_k_next),
    .coef(w_rom_coef)
  );

  always_comb begin
    w_state_next = r_state;
    w_mode_next  = r_mode;
    w_rev_next   = r_rev;
    w_k_next     = r_k;
    w_last_next  = r_last;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_RUN;
          w_mode_next  = mode;
          w_rev_next   = rev;
          w_k_next     = rev ? K_LAST : '0;
          // Either direction starts on its final index only for a 1-term series.
          w_last_next  = (K_LAST == '0);
        end
      end
      ST_RUN: begin
        if (coef_ready) begin
          if (r_last) begin
            w_state_next = ST_IDLE;
            w_k_next     = '0;
            w_last_next  = 1'b0;
            w_done_next  = 1'b1;
          end else begin
            w_k_next    = r_rev ? (r_k - IDX_W'(1)) : (r_k + IDX_W'(1));
            w_last_next = r_rev ? (w_k_next == '0) : (w_k_next == K_LAST);
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_SIN;
      r_rev   <= 1'b0;
      r_k     <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_coef  <= '0;
    end else begin
      r_state <= w_state_next;
      r_mode  <= w_mode_next;
      r_rev   <= w_rev_next;
      r_k     <= w_k_next;
      r_last  <= w_last_next;
      r_done  <= w_done_next;
      r_coef  <= (w_state_next == ST_RUN) ? w_rom_coef : '0;
    end
  end

  assign busy       = (r_state == ST_RUN);
  assign coef_valid = (r_state == ST_RUN);
  assign coef       = r_coef;
  assign term_idx   = r_k;
  assign last       = r_last;
  assign done       = r_done;

endmodule

// File: tb/tb_taylor_coef_seq.sv
// Scoreboard bench: three sequencer instances (defaults, 12-bit fraction,
// single term) checked against hand-computed coefficient sequences.
module tb_taylor_coef_seq;

  typedef struct {
    int coef;
    int idx;
    int last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic start0 = 0, mode0 = 0, rev0 = 0, rdy0 = 1;
  logic busy0, v0, last0, done0;
  logic [15:0] coef0;
  logic [2:0]  idx0;

  logic start1 = 0, mode1 = 0, rev1 = 0, rdy1 = 1;
  logic busy1, v1, last1, done1;
  logic [15:0] coef1;
  logic [2:0]  idx1;

  logic start2 = 0, mode2 = 0, rev2 = 0, rdy2 = 1;
  logic busy2, v2, last2, done2;
  logic [15:0] coef2;
  logic [0:0]  idx2;

  taylor_coef_seq #(.FRAC_W(8), .OUT_W(16), .N_TERMS(5)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .mode(mode0), .rev(rev0), .busy(busy0),
    .coef_valid(v0), .coef_ready(rdy0), .coef(coef0), .term_idx(idx0),
    .last(last0), .done(done0));

  taylor_coef_seq #(.FRAC_W(12), .OUT_W(16), .N_TERMS(5)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode1), .rev(rev1), .busy(busy1),
    .coef_valid(v1), .coef_ready(rdy1), .coef(coef1), .term_idx(idx1),
    .last(last1), .done(done1));

  taylor_coef_seq #(.FRAC_W(8), .OUT_W(16), .N_TERMS(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode2), .rev(rev2), .busy(busy2),
    .coef_valid(v2), .coef_ready(rdy2), .coef(coef2), .term_idx(idx2),
    .last(last2), .done(done2));

  exp_t q0[$], q1[$], q2[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int which, input int c, input int k, input int l);
    exp_t e;
    e.coef = c;
    e.idx  = k;
    e.last = l;
    if (which == 0) q0.push_back(e);
    else if (which == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask

  task automatic no_exp(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got a coefficient, expected none", name);
  endtask

  // Monitor for dut0, including stability of held outputs under backpressure.
  logic st0 = 0, pd0 = 0;
  int   h0c, h0i, h0l;
  always @(negedge clk) begin
    exp_t e;
    if (st0 && v0) begin
      chk("d0 hold coef", int'(coef0), h0c);
      chk("d0 hold idx", int'(idx0), h0i);
      chk("d0 hold last", int'(last0), h0l);
    end
    st0 = v0 && !rdy0;
    h0c = int'(coef0);
    h0i = int'(idx0);
    h0l = int'(last0);
    if (v0 && rdy0) begin
      if (q0.size() == 0) no_exp("d0 unexpected");
      else begin
        e = q0.pop_front();
        $display("d0 coef=%0d k=%0d last=%0d", coef0, idx0, last0);
        chk("d0 coef", int'(coef0), e.coef);
        chk("d0 idx", int'(idx0), e.idx);
        chk("d0 last", int'(last0), e.last);
      end
    end
    if (done0 || pd0) chk("d0 done", int'(done0), int'(pd0));
    pd0 = v0 && rdy0 && last0;
  end

  logic pd1 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (v1 && rdy1) begin
      if (q1.size() == 0) no_exp("d1 unexpected");
      else begin
        e = q1.pop_front();
        $display("d1 coef=%0d k=%0d last=%0d", coef1, idx1, last1);
        chk("d1 coef", int'(coef1), e.coef);
        chk("d1 idx", int'(idx1), e.idx);
        chk("d1 last", int'(last1), e.last);
      end
    end
    if (done1 || pd1) chk("d1 done", int'(done1), int'(pd1));
    pd1 = v1 && rdy1 && last1;
  end

  logic pd2 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (v2 && rdy2) begin
      if (q2.size() == 0) no_exp("d2 unexpected");
      else begin
        e = q2.pop_front();
        $display("d2 coef=%0d k=%0d last=%0d", coef2, idx2, last2);
        chk("d2 coef", int'(coef2), e.coef);
        chk("d2 idx", int'(idx2), e.idx);
        chk("d2 last", int'(last2), e.last);
      end
    end
    if (done2 || pd2) chk("d2 done", int'(done2), int'(pd2));
    pd2 = v2 && rdy2 && last2;
  end

  task automatic wait_idle(input int which);
    int   n;
    logic b;
    n = 0;
    tick;
    b = (which == 0) ? busy0 : (which == 1) ? busy1 : busy2;
    while (n < 40 && b) begin
      tick;
      n++;
      b = (which == 0) ? busy0 : (which == 1) ? busy1 : busy2;
    end
    chk($sformatf("d%0d idle within budget", which), int'(b), 0);
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick;
    chk("reset busy", int'(busy0), 0);
    chk("reset valid", int'(v0), 0);
    chk("reset coef", int'(coef0), 0);
    chk("reset idx", int'(idx0), 0);
    chk("reset last", int'(last0), 0);
    chk("reset done", int'(done0), 0);
    rst = 0;
    tick;

    // Sine forward, defaults
    push(0, 42, 0, 0); push(0, 12, 1, 0); push(0, 6, 2, 0); push(0, 3, 3, 0); push(0, 2, 4, 1);
    start0 = 1;
    tick;
    start0 = 0;
    chk("d0 first latency valid", int'(v0), 1);
    chk("d0 first latency coef", int'(coef0), 42);
    wait_idle(0);

    // Cosine reverse; mode/rev flipped mid-sequence must not matter
    push(0, 2, 4, 0); push(0, 4, 3, 0); push(0, 8, 2, 0); push(0, 21, 1, 0); push(0, 128, 0, 1);
    mode0 = 1; rev0 = 1; start0 = 1;
    tick;
    start0 = 0; mode0 = 0; rev0 = 0;
    wait_idle(0);

    // Sine, 12-bit fraction
    push(1, 682, 0, 0); push(1, 204, 1, 0); push(1, 97, 2, 0); push(1, 56, 3, 0); push(1, 37, 4, 1);
    start1 = 1;
    tick;
    start1 = 0;
    wait_idle(1);

    // Backpressure at k=2 with a stray start during RUN
    push(0, 42, 0, 0); push(0, 12, 1, 0); push(0, 6, 2, 0); push(0, 3, 3, 0); push(0, 2, 4, 1);
    start0 = 1;
    tick;
    start0 = 0;
    tick;
    tick;
    rdy0 = 0; start0 = 1;
    tick;
    start0 = 0;
    tick;
    tick;
    chk("d0 stall coef", int'(coef0), 6);
    chk("d0 stall idx", int'(idx0), 2);
    rdy0 = 1;
    wait_idle(0);

    // Reset mid-sequence at k=3
    push(0, 42, 0, 0); push(0, 12, 1, 0); push(0, 6, 2, 0);
    start0 = 1;
    tick;
    start0 = 0;
    tick;
    tick;
    tick;
    chk("d0 pre-reset idx", int'(idx0), 3);
    rdy0 = 0; rst = 1;
    tick;
    chk("mid-rst busy", int'(busy0), 0);
    chk("mid-rst valid", int'(v0), 0);
    chk("mid-rst coef", int'(coef0), 0);
    chk("mid-rst idx", int'(idx0), 0);
    chk("mid-rst done", int'(done0), 0);
    rst = 0; rdy0 = 1;
    tick;
    push(0, 42, 0, 0); push(0, 12, 1, 0); push(0, 6, 2, 0); push(0, 3, 3, 0); push(0, 2, 4, 1);
    start0 = 1;
    tick;
    start0 = 0;
    chk("d0 restart coef", int'(coef0), 42);
    wait_idle(0);

    // Single term, back-to-back via start in the done cycle
    push(2, 42, 0, 1);
    start2 = 1;
    tick;
    start2 = 0;
    chk("d2 valid", int'(v2), 1);
    chk("d2 last", int'(last2), 1);
    tick;
    chk("d2 done pulse", int'(done2), 1);
    chk("d2 gap valid", int'(v2), 0);
    push(2, 128, 0, 1);
    mode2 = 1; start2 = 1;
    tick;
    start2 = 0;
    chk("d2 second valid", int'(v2), 1);
    tick;
    chk("d2 second done", int'(done2), 1);
    tick;
    tick;

    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
    chk("q2 drained", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
